// File: rtl/spi_mem_if.sv
// Bus bundle between an SPI memory master and the FRAM-style responder.
// Carries the four SPI wires plus the write-commit side channel and status.
interface spi_mem_if #(
    parameter int ADDR_W = 6
);
    logic              spi_clk;
    logic              spi_cs;
    logic              spi_si;
    logic              spi_so;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        status;

    modport master (
        output spi_clk, spi_cs, spi_si,
        input  spi_so, wr_strobe, wr_addr, wr_data, status
    );

    modport slave (
        input  spi_clk, spi_cs, spi_si,
        output spi_so, wr_strobe, wr_addr, wr_data, status
    );
endinterface

// File: rtl/spi_mem_slave.sv
// FM25L16-style SPI FRAM responder (WREN, WRDI, RDSR, WRSR, READ, WRITE).
// SPI mode 0, MSB first, oversampled on clk. Memory is a DEPTH-byte array
// that is never reset; the 16-bit SPI address is truncated to ADDR_W bits.
module spi_mem_slave #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_mem_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_STATUS,
        S_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_WRSR
    } op_t;

    logic w_sclk;
    logic w_cs;
    logic w_si;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_sclk = bus.spi_clk;
            assign w_cs   = bus.spi_cs;
            assign w_si   = bus.spi_si;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sclk_sync;
            logic [SYNC_STAGES-1:0] r_cs_sync;
            logic [SYNC_STAGES-1:0] r_si_sync;

            // Metastability chains; CS resets deasserted so no false frame start.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sclk_sync <= '0;
                    r_cs_sync   <= '1;
                    r_si_sync   <= '0;
                end else begin
                    r_sclk_sync[0] <= bus.spi_clk;
                    r_cs_sync[0]   <= bus.spi_cs;
                    r_si_sync[0]   <= bus.spi_si;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sclk_sync[i] <= r_sclk_sync[i-1];
                        r_cs_sync[i]   <= r_cs_sync[i-1];
                        r_si_sync[i]   <= r_si_sync[i-1];
                    end
                end
            end

            assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
            assign w_cs   = r_cs_sync[SYNC_STAGES-1];
            assign w_si   = r_si_sync[SYNC_STAGES-1];
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    op_t               r_op;
    logic              r_sclk_prev;
    logic              r_cs_prev;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_rx_shift;
    logic [7:0]        r_tx_shift;
    logic              r_so;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wel;
    logic              r_wel_clr;
    logic              r_wpen;
    logic [1:0]        r_bp;
    logic              r_sr_done;
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_mem [DEPTH];

    logic              w_rise;
    logic              w_fall;
    logic              w_cs_fall;
    logic              w_byte_done;
    logic [7:0]        w_rx_byte;
    logic [ADDR_W-1:0] w_rx_addr;
    logic [7:0]        w_status;
    logic              w_mem_we;

    assign w_rise      = w_sclk & ~r_sclk_prev;
    assign w_fall      = ~w_sclk & r_sclk_prev;
    assign w_cs_fall   = ~w_cs & r_cs_prev;
    assign w_rx_byte   = {r_rx_shift, w_si};
    assign w_rx_addr   = w_rx_byte[ADDR_W-1:0];
    assign w_status    = {r_wpen, 3'b000, r_bp, r_wel, 1'b0};
    // A byte completes on the 8th rise; IDLE/IGNORE never count bits.
    assign w_byte_done = w_rise && !w_cs && (r_bit_cnt == 3'd7) &&
                         (r_state != S_IDLE) && (r_state != S_IGNORE);
    assign w_mem_we    = w_byte_done && (r_state == S_DATA) &&
                         (r_op == OP_WRITE) && r_wel;

    assign bus.spi_so    = r_so;
    assign bus.wr_strobe = r_wr_strobe;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.status    = w_status;

    // Edge-detection history for spi_clk and chip select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; CS high always wins and aborts the frame.
    always_comb begin
        w_state_nxt = r_state;
        if (w_cs) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) w_state_nxt = S_OPCODE;
                end
                S_OPCODE: begin
                    if (w_byte_done) begin
                        case (w_rx_byte)
                            8'h05:        w_state_nxt = S_STATUS;
                            8'h01:        w_state_nxt = S_DATA;
                            8'h02, 8'h03: w_state_nxt = S_ADDR_HI;
                            default:      w_state_nxt = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR_HI: begin
                    if (w_byte_done) w_state_nxt = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    if (w_byte_done) w_state_nxt = S_DATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Shift registers, address counter, status bits and write-commit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= OP_READ;
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 7'd0;
            r_tx_shift  <= 8'd0;
            r_so        <= 1'b0;
            r_addr      <= '0;
            r_wel       <= 1'b0;
            r_wel_clr   <= 1'b0;
            r_wpen      <= 1'b0;
            r_bp        <= 2'b00;
            r_sr_done   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'd0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_cs) begin
                r_bit_cnt  <= 3'd0;
                r_tx_shift <= 8'd0;
                r_so       <= 1'b0;
                r_sr_done  <= 1'b0;
                // WRITE/WRSR frames consume the write latch when they end.
                if (r_wel_clr) begin
                    r_wel     <= 1'b0;
                    r_wel_clr <= 1'b0;
                end
            end else begin
                if (w_rise && (r_state != S_IDLE) && (r_state != S_IGNORE)) begin
                    r_rx_shift <= w_rx_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                // Mode 0: MISO changes on the falling edge only.
                if (w_fall) begin
                    if ((r_state == S_DATA) || (r_state == S_STATUS)) begin
                        r_so       <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end else begin
                        r_so <= 1'b0;
                    end
                end
                if (w_byte_done) begin
                    case (r_state)
                        S_OPCODE: begin
                            case (w_rx_byte)
                                8'h06: r_wel <= 1'b1;
                                8'h04: r_wel <= 1'b0;
                                8'h05: r_tx_shift <= w_status;
                                8'h01: begin
                                    r_op      <= OP_WRSR;
                                    r_wel_clr <= 1'b1;
                                end
                                8'h02: begin
                                    r_op      <= OP_WRITE;
                                    r_wel_clr <= 1'b1;
                                end
                                8'h03: r_op <= OP_READ;
                                default: ;
                            endcase
                        end
                        S_ADDR_LO: begin
                            if (r_op == OP_READ) begin
                                r_tx_shift <= r_mem[w_rx_addr];
                                r_addr     <= w_rx_addr + ADDR_W'(1);
                            end else begin
                                r_addr <= w_rx_addr;
                            end
                        end
                        S_DATA: begin
                            case (r_op)
                                OP_READ: begin
                                    r_tx_shift <= r_mem[r_addr];
                                    r_addr     <= r_addr + ADDR_W'(1);
                                end
                                OP_WRITE: begin
                                    if (r_wel) begin
                                        r_wr_strobe <= 1'b1;
                                        r_wr_addr   <= r_addr;
                                        r_wr_data   <= w_rx_byte;
                                    end
                                    r_addr <= r_addr + ADDR_W'(1);
                                end
                                default: begin
                                    if (r_wel && !r_sr_done) begin
                                        r_wpen    <= w_rx_byte[7];
                                        r_bp      <= w_rx_byte[3:2];
                                        r_sr_done <= 1'b1;
                                    end
                                end
                            endcase
                        end
                        S_STATUS: r_tx_shift <= w_status;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Memory array; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= w_rx_byte;
        end
    end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench for spi_mem_slave: drives SPI mode-0 frames from clk and
// checks MISO bytes, write strobes and the status register.
module tb_spi_mem_slave;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   strobe_cnt;
    int   base;
    logic [5:0] s_addr [$];
    logic [7:0] s_data [$];
    logic [7:0] rx;

    spi_mem_if #(.ADDR_W(6)) bus ();

    spi_mem_slave #(.DEPTH(64), .ADDR_W(6), .SYNC_STAGES(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every committed write, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_strobe === 1'b1) begin
            strobe_cnt++;
            s_addr.push_back(bus.wr_addr);
            s_data.push_back(bus.wr_data);
        end
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        bus.spi_cs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (2) @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Send the top n bits of tx; MISO is sampled just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rxb);
        rxb = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            bus.spi_si = tx[i];
            repeat (2) @(negedge clk);
            rxb[i] = bus.spi_so;
            bus.spi_clk = 1'b1;
            repeat (2) @(negedge clk);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxb);
        spi_bits(tx, 8, rxb);
    endtask

    task automatic cmd1(input logic [7:0] op);
        logic [7:0] d;
        cs_low();
        spi_byte(op, d);
        cs_high();
    endtask

    initial begin
        total = 0;
        bad = 0;
        strobe_cnt = 0;
        rst_n = 1'b0;
        bus.spi_clk = 1'b0;
        bus.spi_cs = 1'b1;
        bus.spi_si = 1'b0;
        repeat (3) @(negedge clk);
        check8("rst_so", {7'd0, bus.spi_so}, 8'h00);
        check8("rst_strobe", {7'd0, bus.wr_strobe}, 8'h00);
        check8("rst_wr_addr", {2'b00, bus.wr_addr}, 8'h00);
        check8("rst_wr_data", bus.wr_data, 8'h00);
        check8("rst_status", bus.status, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // WREN then RDSR streams 0x02 repeatedly.
        cmd1(8'h06);
        check8("wren_status", bus.status, 8'h02);
        cs_low();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        check8("rdsr_b0", rx, 8'h02);
        spi_byte(8'h00, rx);
        check8("rdsr_b1", rx, 8'h02);
        cs_high();
        check8("rdsr_keeps_wel", bus.status, 8'h02);

        // WRDI clears WEL; a WREN cut short at 7 bits does nothing.
        cmd1(8'h04);
        check8("wrdi_status", bus.status, 8'h00);
        cs_low();
        spi_bits(8'h06, 7, rx);
        cs_high();
        check8("wren_abort", bus.status, 8'h00);

        // Single-byte write to address 5.
        cmd1(8'h06);
        base = strobe_cnt;
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h05, rx);
        spi_byte(8'hA5, rx);
        cs_high();
        checki("wr5_cnt", strobe_cnt - base, 1);
        if (strobe_cnt - base == 1) begin
            check8("wr5_addr", {2'b00, s_addr[base]}, 8'h05);
            check8("wr5_data", s_data[base], 8'hA5);
        end
        check8("wr5_wel_clr", bus.status, 8'h00);

        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        cs_high();
        check8("rd5", rx, 8'hA5);

        // Burst write across the top of memory wraps to 0.
        cmd1(8'h06);
        base = strobe_cnt;
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h3F, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        cs_high();
        checki("wrap_cnt", strobe_cnt - base, 2);
        if (strobe_cnt - base == 2) begin
            check8("wrap_a0", {2'b00, s_addr[base]}, 8'h3F);
            check8("wrap_d0", s_data[base], 8'h11);
            check8("wrap_a1", {2'b00, s_addr[base+1]}, 8'h00);
            check8("wrap_d1", s_data[base+1], 8'h22);
        end
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h3F, rx);
        spi_byte(8'h00, rx);
        check8("wrap_rd0", rx, 8'h11);
        spi_byte(8'h00, rx);
        check8("wrap_rd1", rx, 8'h22);
        cs_high();

        // Seed address 3, then a write without WREN must be dropped.
        cmd1(8'h06);
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'h3C, rx);
        cs_high();
        base = strobe_cnt;
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'h5A, rx);
        cs_high();
        checki("nowel_cnt", strobe_cnt - base, 0);
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        cs_high();
        check8("nowel_rd3", rx, 8'h3C);

        // Partial data byte is discarded but WEL is still consumed.
        cmd1(8'h06);
        base = strobe_cnt;
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h07, rx);
        spi_bits(8'hFF, 4, rx);
        cs_high();
        checki("partial_cnt", strobe_cnt - base, 0);
        check8("partial_wel", bus.status, 8'h00);

        // Unknown opcode keeps MISO low.
        cs_low();
        spi_byte(8'hFF, rx);
        spi_byte(8'h00, rx);
        check8("ignore_rx", rx, 8'h00);
        check8("ignore_so", {7'd0, bus.spi_so}, 8'h00);
        cs_high();

        // WRSR stores WPEN/BP; WEL is cleared at frame end.
        cmd1(8'h06);
        cs_low();
        spi_byte(8'h01, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h00, rx);
        cs_high();
        check8("wrsr_status", bus.status, 8'h8C);
        cs_low();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        cs_high();
        check8("wrsr_rdsr", rx, 8'h8C);

        // Reset in the middle of a READ frame.
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_bits(8'h05, 3, rx);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check8("midrst_so", {7'd0, bus.spi_so}, 8'h00);
        check8("midrst_status", bus.status, 8'h00);
        bus.spi_cs = 1'b1;
        bus.spi_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cs_low();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        cs_high();
        check8("postrst_rdsr", rx, 8'h00);
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        cs_high();
        check8("postrst_rd5", rx, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
